// File: rtl/proc_pkg.sv
// Shared widths and types for the execute stage: ALU opcodes, branch conditions,
// the NZCV flag layout and the multiplier sequencing states.
package proc_pkg;

  localparam int W     = 32;
  localparam int IMM_W = 19;
  localparam int CNT_W = $clog2(W);

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_SLL = 4'd5,
    ALU_SRL = 4'd6,
    ALU_SRA = 4'd7,
    ALU_MUL = 4'd8
  } alu_op_e;

  typedef enum logic [3:0] {
    COND_AL = 4'd0,
    COND_EQ = 4'd1,
    COND_NE = 4'd2,
    COND_LT = 4'd3,
    COND_GE = 4'd4
  } cond_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_BUSY = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_e;

  function automatic logic [W-1:0] sext_imm(input logic [IMM_W-1:0] imm);
    return {{(W-IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

endpackage

// File: rtl/seq_multiplier.sv
// Radix-2 shift-add multiplier: one partial-product step per cycle over W cycles,
// producing the low W bits of the product. Can be held and aborted by the pipeline.
module seq_multiplier
  import proc_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_start,
  input  logic         i_hold,
  input  logic         i_abort,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic         o_busy,
  output logic         o_done,
  output logic [W-1:0] o_product
);

  mul_state_e       r_state;
  mul_state_e       w_nextState;
  logic [CNT_W-1:0] r_cnt;
  logic [W-1:0]     r_mcand;
  logic [W-1:0]     r_mplier;
  logic [W-1:0]     r_acc;
  logic             w_start;
  logic             w_step;
  logic             w_lastStep;

  assign w_start    = i_start && (r_state == MUL_IDLE);
  assign w_step     = (r_state == MUL_BUSY) && !i_hold && !i_abort;
  assign w_lastStep = (r_cnt == CNT_W'(W - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= MUL_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Abort beats hold; DONE waits under hold until the result is taken downstream.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      MUL_IDLE: begin
        if (w_start) w_nextState = MUL_BUSY;
      end
      MUL_BUSY: begin
        if (i_abort)                 w_nextState = MUL_IDLE;
        else if (w_step && w_lastStep) w_nextState = MUL_DONE;
      end
      MUL_DONE: begin
        if (i_abort || !i_hold) w_nextState = MUL_IDLE;
      end
      default: w_nextState = MUL_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
    end else if (w_start) begin
      r_cnt    <= '0;
      r_mcand  <= i_a;
      r_mplier <= i_b;
      r_acc    <= '0;
    end else if (w_step) begin
      if (r_mplier[0]) r_acc <= r_acc + r_mcand;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 1'b1;
    end
  end

  assign o_busy    = (r_state == MUL_BUSY);
  assign o_done    = (r_state == MUL_DONE);
  assign o_product = r_acc;

endmodule

// File: rtl/execute_stage.sv
// EX stage: ALU, sequential multiplier, NZCV flags, branch/jump resolution and the
// E/M pipeline register. Reports multiplier stalls and PC redirects to hazard logic.
module execute_stage
  import proc_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pcload_E,
  input  logic             regw_E,
  input  logic             memw_E,
  input  logic             regmem_E,
  input  logic             branch_E,
  input  logic             ALUope_E,
  input  logic             flag_E,
  input  logic [3:0]       ALUctrl_E,
  input  logic [3:0]       regScr_E,
  input  logic [W-1:0]     regA_E,
  input  logic [W-1:0]     regB_E,
  input  logic [IMM_W-1:0] inm_E,
  input  logic [W-1:0]     pc_E,
  input  logic             stall_M,
  input  logic             flush_M,
  output logic             stall_E,
  output logic             redirect_E,
  output logic [W-1:0]     pctarget_E,
  output logic             regw_M,
  output logic             memw_M,
  output logic             regmem_M,
  output logic [3:0]       regScr_M,
  output logic [W-1:0]     aluRes_M,
  output logic [W-1:0]     wdata_M,
  output logic [3:0]       flags_q
);

  logic [W-1:0]     w_immExt;
  logic [W-1:0]     w_opB;
  logic [CNT_W-1:0] w_shamt;
  logic [W:0]       w_sum;
  logic [W:0]       w_diff;
  logic [W-1:0]     w_aluRes;
  logic             w_carry;
  logic             w_ovf;
  logic [W-1:0]     w_result;
  logic [W-1:0]     w_product;
  logic             w_mulReq;
  logic             w_mulStart;
  logic             w_mulBusy;
  logic             w_mulDone;
  logic             w_idle;
  logic             w_bubble;
  logic             w_condTrue;
  logic             w_flagWe;
  flags_t           w_flagsNext;
  flags_t           r_flags;

  assign w_immExt = sext_imm(inm_E);
  assign w_opB    = ALUope_E ? w_immExt : regB_E;
  assign w_shamt  = w_opB[CNT_W-1:0];
  assign w_sum    = {1'b0, regA_E} + {1'b0, w_opB};
  assign w_diff   = {1'b0, regA_E} - {1'b0, w_opB};

  // C is the unsigned carry out for ADD and the no-borrow indication for SUB.
  always_comb begin
    w_aluRes = '0;
    w_carry  = 1'b0;
    w_ovf    = 1'b0;
    case (alu_op_e'(ALUctrl_E))
      ALU_ADD: begin
        w_aluRes = w_sum[W-1:0];
        w_carry  = w_sum[W];
        w_ovf    = (regA_E[W-1] == w_opB[W-1]) && (w_sum[W-1] != regA_E[W-1]);
      end
      ALU_SUB: begin
        w_aluRes = w_diff[W-1:0];
        w_carry  = ~w_diff[W];
        w_ovf    = (regA_E[W-1] != w_opB[W-1]) && (w_diff[W-1] != regA_E[W-1]);
      end
      ALU_AND: w_aluRes = regA_E & w_opB;
      ALU_OR:  w_aluRes = regA_E | w_opB;
      ALU_XOR: w_aluRes = regA_E ^ w_opB;
      ALU_SLL: w_aluRes = regA_E << w_shamt;
      ALU_SRL: w_aluRes = regA_E >> w_shamt;
      ALU_SRA: w_aluRes = $unsigned($signed(regA_E) >>> w_shamt);
      default: w_aluRes = '0;
    endcase
  end

  assign w_mulReq   = (alu_op_e'(ALUctrl_E) == ALU_MUL) && !branch_E;
  assign w_idle     = !w_mulBusy && !w_mulDone;
  assign w_mulStart = w_idle && w_mulReq && !stall_M && !flush_M;

  seq_multiplier u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_start   (w_mulStart),
    .i_hold    (stall_M),
    .i_abort   (flush_M),
    .i_a       (regA_E),
    .i_b       (w_opB),
    .o_busy    (w_mulBusy),
    .o_done    (w_mulDone),
    .o_product (w_product)
  );

  assign w_result = w_mulDone ? w_product : w_aluRes;
  assign w_bubble = (w_idle && w_mulReq) || w_mulBusy;
  assign stall_E  = rst_n && w_bubble;

  always_comb begin
    w_flagsNext   = '0;
    w_flagsNext.n = w_result[W-1];
    w_flagsNext.z = (w_result == '0);
    w_flagsNext.c = w_carry && !w_mulDone;
    w_flagsNext.v = w_ovf && !w_mulDone;
  end

  // Branches read only the registered flags; a flag-setting op in E is not forwarded.
  always_comb begin
    w_condTrue = 1'b0;
    case (cond_e'(ALUctrl_E))
      COND_AL: w_condTrue = 1'b1;
      COND_EQ: w_condTrue = r_flags.z;
      COND_NE: w_condTrue = !r_flags.z;
      COND_LT: w_condTrue = r_flags.n ^ r_flags.v;
      COND_GE: w_condTrue = !(r_flags.n ^ r_flags.v);
      default: w_condTrue = 1'b0;
    endcase
  end

  assign redirect_E = rst_n && w_idle && !stall_M && (pcload_E || (branch_E && w_condTrue));
  assign pctarget_E = pcload_E ? regA_E : (pc_E + w_immExt);

  assign w_flagWe = flag_E && !flush_M && !stall_M && !w_bubble;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flags <= '0;
    end else if (w_flagWe) begin
      r_flags <= w_flagsNext;
    end
  end

  assign flags_q = r_flags;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regw_M   <= 1'b0;
      memw_M   <= 1'b0;
      regmem_M <= 1'b0;
      regScr_M <= '0;
      aluRes_M <= '0;
      wdata_M  <= '0;
    end else if (flush_M || (w_bubble && !stall_M)) begin
      regw_M   <= 1'b0;
      memw_M   <= 1'b0;
      regmem_M <= 1'b0;
      regScr_M <= '0;
      aluRes_M <= '0;
      wdata_M  <= '0;
    end else if (!stall_M) begin
      regw_M   <= regw_E;
      memw_M   <= memw_E;
      regmem_M <= regmem_E;
      regScr_M <= regScr_E;
      aluRes_M <= w_result;
      wdata_M  <= regB_E;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Directed and randomized bench for execute_stage against an arithmetic reference model.
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pcload, regw, memw, regmem, branch, aluope, flagE, stallM, flushM;
  logic [3:0]  aluctrl, regScr;
  logic [31:0] regA, regB, pc;
  logic [18:0] inm;
  logic        stallE, redirectE, regwM, memwM, regmemM;
  logic [31:0] pctarget, aluResM, wdataM;
  logic [3:0]  regScrM, flagsQ;

  int          total = 0;
  int          bad   = 0;
  logic [3:0]  expFlags = 4'b0000;

  always #5 clk = ~clk;

  execute_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pcload_E   (pcload),
    .regw_E     (regw),
    .memw_E     (memw),
    .regmem_E   (regmem),
    .branch_E   (branch),
    .ALUope_E   (aluope),
    .flag_E     (flagE),
    .ALUctrl_E  (aluctrl),
    .regScr_E   (regScr),
    .regA_E     (regA),
    .regB_E     (regB),
    .inm_E      (inm),
    .pc_E       (pc),
    .stall_M    (stallM),
    .flush_M    (flushM),
    .stall_E    (stallE),
    .redirect_E (redirectE),
    .pctarget_E (pctarget),
    .regw_M     (regwM),
    .memw_M     (memwM),
    .regmem_M   (regmemM),
    .regScr_M   (regScrM),
    .aluRes_M   (aluResM),
    .wdata_M    (wdataM),
    .flags_q    (flagsQ)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sextModel(input logic [18:0] imm);
    int v;
    v = int'($signed(imm));
    return 32'(v);
  endfunction

  // Flags come from exact integer arithmetic compared with the wrapped 32-bit result.
  function automatic void aluModel(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] res, output logic [3:0] fl);
    longint unsigned ua, ub;
    longint          sa, sb;
    logic            c, v;
    ua = a; ub = b;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    c = 1'b0; v = 1'b0;
    case (op)
      4'd0: begin res = a + b; c = (ua + ub) != longint'(res); v = (sa + sb) != longint'($signed(res)); end
      4'd1: begin res = a - b; c = (a >= b); v = (sa - sb) != longint'($signed(res)); end
      4'd2: res = a & b;
      4'd3: res = a | b;
      4'd4: res = a ^ b;
      4'd5: res = a << b[4:0];
      4'd6: res = a >> b[4:0];
      4'd7: res = 32'($signed(a) >>> b[4:0]);
      4'd8: res = a * b;
      default: res = 32'd0;
    endcase
    fl = {res[31], res == 32'd0, c, v};
  endfunction

  function automatic logic condModel(input logic [3:0] cond, input logic [3:0] fl);
    case (cond)
      4'd0: return 1'b1;
      4'd1: return fl[2];
      4'd2: return !fl[2];
      4'd3: return fl[3] != fl[0];
      4'd4: return fl[3] == fl[0];
      default: return 1'b0;
    endcase
  endfunction

  task automatic applyStimulus(input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                               input logic useImm, input logic [18:0] imm, input logic fl,
                               input logic br, input logic jmp, input logic [31:0] pcVal);
    aluctrl = ctrl; regA = a; regB = b; aluope = useImm; inm = imm; flagE = fl;
    branch = br; pcload = jmp; pc = pcVal;
    regw   = !(br || jmp);
    memw   = 1'($urandom);
    regmem = 1'($urandom);
    regScr = 4'($urandom);
  endtask

  task automatic doAlu(input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                       input logic useImm, input logic [18:0] imm, input logic fl,
                       input logic br, input logic jmp, input logic [31:0] pcVal, input string tag);
    logic [31:0] bEff, res, tgt;
    logic [3:0]  nf;
    logic        expRd;
    applyStimulus(ctrl, a, b, useImm, imm, fl, br, jmp, pcVal);
    bEff  = useImm ? sextModel(imm) : b;
    aluModel(ctrl, a, bEff, res, nf);
    expRd = jmp || (br && condModel(ctrl, expFlags));
    tgt   = jmp ? a : pcVal + sextModel(imm);
    #1;
    checkOutput({tag, ".stall"}, stallE, 0);
    checkOutput({tag, ".redirect"}, redirectE, expRd);
    if (expRd) checkOutput({tag, ".target"}, pctarget, tgt);
    @(posedge clk); #1;
    if (fl) expFlags = nf;
    checkOutput({tag, ".regw"}, regwM, regw);
    checkOutput({tag, ".memw"}, memwM, memw);
    checkOutput({tag, ".regmem"}, regmemM, regmem);
    checkOutput({tag, ".regScr"}, regScrM, regScr);
    checkOutput({tag, ".aluRes"}, aluResM, res);
    checkOutput({tag, ".wdata"}, wdataM, b);
    checkOutput({tag, ".flags"}, flagsQ, expFlags);
  endtask

  task automatic doMul(input logic [31:0] a, input logic [31:0] b, input logic fl, input string tag);
    logic [31:0] res;
    logic [3:0]  nf;
    int          n;
    applyStimulus(4'd8, a, b, 1'b0, 19'd0, fl, 1'b0, 1'b0, 32'd0);
    aluModel(4'd8, a, b, res, nf);
    n = 0;
    #1;
    while (stallE === 1'b1 && n < 40) begin
      n++;
      @(posedge clk); #1;
      checkOutput({tag, ".bubble"}, regwM, 0);
    end
    checkOutput({tag, ".stallLen"}, n, 33);
    @(posedge clk); #1;
    if (fl) expFlags = nf;
    checkOutput({tag, ".aluRes"}, aluResM, res);
    checkOutput({tag, ".regw"}, regwM, 1);
    checkOutput({tag, ".wdata"}, wdataM, b);
    checkOutput({tag, ".flags"}, flagsQ, expFlags);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired before the sequence completed");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int          kind;
    logic [3:0]  ctrl;
    logic [31:0] a, b;
    logic [31:0] heldRes;
    logic [3:0]  heldScr;

    rst_n = 1'b0; stallM = 1'b0; flushM = 1'b0;
    applyStimulus(4'd0, 32'd0, 32'd0, 1'b0, 19'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    memw = 1'b0; regmem = 1'b0; regScr = 4'd0;
    @(posedge clk); #1;
    checkOutput("rst.stall", stallE, 0);
    checkOutput("rst.redirect", redirectE, 0);
    checkOutput("rst.regw", regwM, 0);
    checkOutput("rst.memw", memwM, 0);
    checkOutput("rst.regmem", regmemM, 0);
    checkOutput("rst.regScr", regScrM, 0);
    checkOutput("rst.aluRes", aluResM, 0);
    checkOutput("rst.wdata", wdataM, 0);
    checkOutput("rst.flags", flagsQ, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    doAlu(4'd0, 32'h0000FFFF, 32'hDEADBEEF, 1'b1, 19'h00401, 1'b1, 1'b0, 1'b0, 32'h0, "add");
    checkOutput("addConst.aluRes", aluResM, 32'h00010400);
    checkOutput("addConst.flags", flagsQ, 4'b0000);

    doAlu(4'd1, 32'd5, 32'd5, 1'b0, 19'd0, 1'b1, 1'b0, 1'b0, 32'h0, "sub");
    checkOutput("subConst.flags", flagsQ, 4'b0110);
    doAlu(4'd1, 32'h0, 32'h0, 1'b0, 19'h7FFFC, 1'b0, 1'b1, 1'b0, 32'h100, "beq");
    doAlu(4'd2, 32'h0, 32'h0, 1'b0, 19'h7FFFC, 1'b0, 1'b1, 1'b0, 32'h100, "bne");

    // Reset asserted while the multiplier is BUSY, with the MUL still presented in E.
    applyStimulus(4'd8, 32'h12345678, 32'h9ABCDEF1, 1'b0, 19'd0, 1'b1, 1'b0, 1'b0, 32'h0);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("preRst.stall", stallE, 1);
    rst_n = 1'b0;
    #1;
    expFlags = 4'b0000;
    checkOutput("midRst.stall", stallE, 0);
    checkOutput("midRst.redirect", redirectE, 0);
    checkOutput("midRst.regw", regwM, 0);
    checkOutput("midRst.aluRes", aluResM, 0);
    checkOutput("midRst.flags", flagsQ, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    doAlu(4'd0, 32'h00000080, 32'h1, 1'b0, 19'd0, 1'b0, 1'b0, 1'b1, 32'h0, "postRstJump");

    doMul(32'h0000FFFF, 32'h00000801, 1'b1, "mul");
    checkOutput("mulConst.aluRes", aluResM, 32'h0800F7FF);

    // Flush lands in the tenth BUSY cycle; the hazard logic replaces E with an ADD.
    applyStimulus(4'd8, 32'h00001234, 32'h00000077, 1'b0, 19'd0, 1'b1, 1'b0, 1'b0, 32'h0);
    repeat (10) @(posedge clk);
    #1;
    flushM = 1'b1;
    applyStimulus(4'd0, 32'd3, 32'd4, 1'b0, 19'd0, 1'b1, 1'b0, 1'b0, 32'h0);
    @(posedge clk); #1;
    checkOutput("flush.regw", regwM, 0);
    checkOutput("flush.aluRes", aluResM, 0);
    checkOutput("flush.flags", flagsQ, expFlags);
    flushM = 1'b0;
    #1;
    checkOutput("flush.stallNext", stallE, 0);
    doAlu(4'd0, 32'd3, 32'd4, 1'b0, 19'd0, 1'b1, 1'b0, 1'b0, 32'h0, "postFlush");

    stallM = 1'b1; flushM = 1'b1;
    applyStimulus(4'd3, 32'hF0F0F0F0, 32'h0F0F0F0F, 1'b0, 19'd0, 1'b1, 1'b0, 1'b0, 32'h0);
    @(posedge clk); #1;
    checkOutput("flushStall.regw", regwM, 0);
    checkOutput("flushStall.aluRes", aluResM, 0);
    checkOutput("flushStall.wdata", wdataM, 0);
    stallM = 1'b0; flushM = 1'b0;

    doAlu(4'd0, 32'h11, 32'h22, 1'b0, 19'd0, 1'b0, 1'b0, 1'b0, 32'h0, "preStall");
    heldRes = 32'h33;
    heldScr = regScr;
    applyStimulus(4'd0, 32'h00000040, 32'h5, 1'b0, 19'd0, 1'b0, 1'b0, 1'b1, 32'h200);
    stallM = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checkOutput("stall.redirect", redirectE, 0);
      @(posedge clk); #1;
      checkOutput("stall.aluRes", aluResM, heldRes);
      checkOutput("stall.regw", regwM, 1);
      checkOutput("stall.regScr", regScrM, heldScr);
    end
    stallM = 1'b0;
    #1;
    checkOutput("release.redirect", redirectE, 1);
    checkOutput("release.target", pctarget, 32'h00000040);
    @(posedge clk); #1;
    checkOutput("release.aluRes", aluResM, 32'h45);
    checkOutput("release.regw", regwM, 0);

    for (int i = 0; i < 120; i++) begin
      kind = int'($urandom_range(0, 9));
      a = $urandom;
      b = (kind == 9) ? a : $urandom;
      if (kind == 0) begin
        doAlu(4'($urandom_range(0, 7)), a, b, 1'($urandom), 19'($urandom), 1'b0,
              1'b0, 1'b1, $urandom, "rndJump");
      end else if (kind <= 2) begin
        doAlu(4'($urandom_range(0, 7)), a, b, 1'($urandom), 19'($urandom), 1'($urandom),
              1'b1, 1'b0, $urandom, "rndBranch");
      end else begin
        ctrl = 4'($urandom_range(0, 15));
        if (ctrl == 4'd8) ctrl = 4'd9;
        doAlu(ctrl, a, b, 1'($urandom), 19'($urandom), 1'($urandom),
              1'b0, 1'b0, $urandom, "rndAlu");
      end
      if (i % 30 == 29) doMul($urandom, $urandom, 1'($urandom), "rndMul");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
